button_panel: RTL and testbench

Parametrised VGA overlay that draws a horizontal row of `NUM_BTN` labelled buttons and reports mouse clicks on them. It is the generalised successor to the fixed three-button DEAL/HIT/STAND drawer. Labels, enables and click detection are runtime-driven. It sits in the `vga_if` chain after the card/table layers and before the mouse-pointer layer. It takes the mouse position and left button from the mouse controller and emits one-cycle `btn_click` pulses to the game FSM.

---
 rtl/button_panel_pkg.sv | 42 ++++
 rtl/vga_if.sv | 13 +
 rtl/font_rom_5x7.sv | 56 +++++
 rtl/button_panel.sv | 215 +++++++++++++++++++++
 tb/tb_button_panel.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/button_panel_pkg.sv
// Shared constants, char codes and small colour helpers for the button overlay.
package button_panel_pkg;

  localparam int CHAR_BITS = 5;
  localparam int GLYPH_W   = 5;
  localparam int GLYPH_H   = 7;

  localparam logic [CHAR_BITS-1:0] CH_BLANK = 5'd0;
  localparam logic [CHAR_BITS-1:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
  localparam logic [CHAR_BITS-1:0] CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
  localparam logic [CHAR_BITS-1:0] CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
  localparam logic [CHAR_BITS-1:0] CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
  localparam logic [CHAR_BITS-1:0] CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
  localparam logic [CHAR_BITS-1:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
  localparam logic [CHAR_BITS-1:0] CH_Y = 5'd25, CH_Z = 5'd26;

  typedef enum logic {IDLE, PRESSED} click_state_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // Hover highlight: +4 per 4-bit channel, clipped at 0xF.
  function automatic logic [11:0] rgb_brighten(input logic [11:0] c);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      r[i*4 +: 4] = (c[i*4 +: 4] > 4'd11) ? 4'hF : c[i*4 +: 4] + 4'd4;
    return r;
  endfunction

  function automatic logic [11:0] rgb_dim(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + pixel bundle passed between overlay layers.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/font_rom_5x7.sv
// Registered 5x7 glyph ROM for A-Z; row 0 is the top row, bit 4 the leftmost column.
module font_rom_5x7
  import button_panel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHAR_BITS-1:0] code,
  input  logic [2:0]           row,
  output logic [GLYPH_W-1:0]   bits
);

  logic [34:0] glyph;
  logic [5:0]  base;

  always_comb begin
    glyph = '0;
    case (code)
      CH_A: glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
      CH_B: glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
      CH_C: glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
      CH_D: glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
      CH_E: glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
      CH_F: glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
      CH_G: glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
      CH_H: glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
      CH_I: glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
      CH_J: glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
      CH_K: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
      CH_L: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
      CH_M: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
      CH_N: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
      CH_O: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
      CH_P: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
      CH_Q: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
      CH_R: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
      CH_S: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
      CH_T: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
      CH_U: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
      CH_V: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
      CH_W: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
      CH_X: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
      CH_Y: glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
      CH_Z: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
      default: glyph = '0;
    endcase
  end

  assign base = 6'(3'd6 - row) * 6'd5;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          bits <= '0;
    else if (row > 3'd6) bits <= '0;
    else               bits <= glyph[base +: 5];
  end

endmodule

// File: rtl/button_panel.sv
// Row of NUM_BTN labelled buttons drawn over the VGA stream, with click detection.
module button_panel
  import button_panel_pkg::*;
#(
  parameter int NUM_BTN   = 3,
  parameter int MAX_CHARS = 5,
  parameter int BTN_X0    = 100,
  parameter int BTN_PITCH = 200,
  parameter int BTN_Y     = 400,
  parameter int BTN_W     = 100,
  parameter int BTN_H     = 50,
  parameter int SCALE     = 3,
  parameter int TEXT_DY   = 15,
  parameter logic [NUM_BTN*12-1:0] BTN_RGB = {12'h0F0, 12'h00F, 12'hF00}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_BTN-1:0]                 btn_en,
  input  logic [NUM_BTN*MAX_CHARS*5-1:0]     btn_label,
  input  logic [NUM_BTN*4-1:0]               btn_len,
  input  logic [11:0]                        mouse_x,
  input  logic [11:0]                        mouse_y,
  input  logic                               mouse_left,
  output logic [NUM_BTN-1:0]                 btn_click,
  vga_if.in                                  vga_in,
  vga_if.out                                 vga_out
);

  localparam int IDW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int CW  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [11:0] PITCH = 12'(GLYPH_W*SCALE + 1);
  localparam logic [11:0] GWPIX = 12'(GLYPH_W*SCALE);
  localparam logic [11:0] SC    = 12'(SCALE);
  localparam logic [11:0] TOP   = 12'(BTN_Y);
  localparam logic [11:0] BOT   = 12'(BTN_Y + BTN_H);
  localparam logic [11:0] TY0   = 12'(TEXT_DY);
  localparam logic [11:0] TY1   = 12'(TEXT_DY + GLYPH_H*SCALE);
  localparam logic [11:0] BW    = 12'(BTN_W);
  localparam logic [3:0]  MAXC  = 4'(MAX_CHARS);

  logic [NUM_BTN-1:0]                 pix_in, mouse_in, txt;
  logic [NUM_BTN-1:0][CHAR_BITS-1:0]  code_a;
  logic [NUM_BTN-1:0][2:0]            row_a, col_a;
  logic [NUM_BTN-1:0][11:0]           base_a;

  assign base_a = BTN_RGB;

  // ---------------- per-button geometry and text addressing ----------------
  for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
    localparam logic [11:0] LEFT  = 12'(BTN_X0 + k*BTN_PITCH);
    localparam logic [11:0] RIGHT = 12'(BTN_X0 + k*BTN_PITCH + BTN_W);

    logic [3:0]  len;
    logic [11:0] tw, toff, rx, ry, dx, colp;
    logic [MAX_CHARS-1:0][CHAR_BITS-1:0] lbl;

    assign lbl  = btn_label[k*MAX_CHARS*CHAR_BITS +: MAX_CHARS*CHAR_BITS];
    assign len  = (btn_len[k*4 +: 4] > MAXC) ? MAXC : btn_len[k*4 +: 4];
    assign tw   = 12'(len) * PITCH - 12'd1;
    assign toff = (BW - tw) >> 1;
    // rx/ry/dx are only meaningful once the range checks below hold.
    assign rx   = vga_in.hcount - LEFT;
    assign ry   = vga_in.vcount - TOP;
    assign dx   = rx - toff;
    assign colp = dx % PITCH;

    assign pix_in[k]   = btn_en[k] && (vga_in.hcount >= LEFT) && (vga_in.hcount < RIGHT)
                         && (vga_in.vcount >= TOP) && (vga_in.vcount < BOT);
    assign mouse_in[k] = (mouse_x >= LEFT) && (mouse_x < RIGHT)
                         && (mouse_y >= TOP) && (mouse_y < BOT);
    assign txt[k]      = pix_in[k] && (len != 4'd0) && (rx >= toff) && (rx < toff + tw)
                         && (ry >= TY0) && (ry < TY1) && (colp < GWPIX);
    assign code_a[k]   = lbl[CW'(dx / PITCH)];
    assign col_a[k]    = 3'(colp / SC);
    assign row_a[k]    = 3'((ry - TY0) / SC);
  end

  // Lowest index wins on overlap: scan downwards so the last hit kept is the smallest k.
  logic           hit_vld, mhit_vld;
  logic [IDW-1:0] hit_id, mhit_id;

  always_comb begin
    hit_vld  = 1'b0;
    hit_id   = '0;
    mhit_vld = 1'b0;
    mhit_id  = '0;
    for (int k = NUM_BTN-1; k >= 0; k--) begin
      if (pix_in[k]) begin
        hit_vld = 1'b1;
        hit_id  = IDW'(k);
      end
      if (btn_en[k] && mouse_in[k]) begin
        mhit_vld = 1'b1;
        mhit_id  = IDW'(k);
      end
    end
  end

  // ---------------- stage 1: hit/col registers, glyph row via ROM ----------------
  logic                 s1_hit, s1_txt;
  logic [IDW-1:0]       s1_id;
  logic [2:0]           s1_col;
  vga_t                 s1_vga;
  logic [CHAR_BITS-1:0] rom_code;
  logic [GLYPH_W-1:0]   glyph_row;

  assign rom_code = (hit_vld && txt[hit_id]) ? code_a[hit_id] : CH_BLANK;

  font_rom_5x7 u_font (
    .clk  (clk),
    .rst  (rst),
    .code (rom_code),
    .row  (row_a[hit_id]),
    .bits (glyph_row)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hit <= 1'b0;
      s1_txt <= 1'b0;
      s1_id  <= '0;
      s1_col <= '0;
      s1_vga <= '0;
    end else begin
      s1_hit <= hit_vld;
      s1_txt <= hit_vld && txt[hit_id];
      s1_id  <= hit_id;
      s1_col <= col_a[hit_id];
      s1_vga <= '{hcount: vga_in.hcount, vcount: vga_in.vcount, hsync: vga_in.hsync,
                  vsync: vga_in.vsync, hblnk: vga_in.hblnk, vblnk: vga_in.vblnk,
                  rgb: vga_in.rgb};
    end
  end

  // ---------------- mouse sync, edge register, click FSM ----------------
  logic [1:0]     sync_q;
  logic           lvl_q, rise_q, fall_q;
  click_state_t   state;
  logic [IDW-1:0] id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], mouse_left};
      lvl_q  <= sync_q[1];
      rise_q <= sync_q[1] & ~lvl_q;
      fall_q <= ~sync_q[1] & lvl_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      id        <= '0;
      btn_click <= '0;
    end else begin
      btn_click <= '0;
      case (state)
        IDLE: if (rise_q && mhit_vld) begin
          state <= PRESSED;
          id    <= mhit_id;
        end
        PRESSED: begin
          if (!btn_en[id]) begin
            state <= IDLE;
          end else if (fall_q) begin
            state <= IDLE;
            if (mouse_in[id]) btn_click[id] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- stage 2: bit select and colour mux ----------------
  logic [11:0] base, bg, pix;
  logic        lit;

  always_comb begin
    base = base_a[s1_id];
    if (state == PRESSED && id == s1_id)      bg = rgb_dim(base);
    else if (state == IDLE && mouse_in[s1_id]) bg = rgb_brighten(base);
    else                                       bg = base;
    lit = s1_txt && glyph_row[3'd4 - s1_col];
    if (s1_vga.hblnk || s1_vga.vblnk) pix = 12'h000;
    else if (s1_hit)                  pix = lit ? 12'hFFF : bg;
    else                              pix = s1_vga.rgb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= s1_vga.hcount;
      vga_out.vcount <= s1_vga.vcount;
      vga_out.hsync  <= s1_vga.hsync;
      vga_out.vsync  <= s1_vga.vsync;
      vga_out.hblnk  <= s1_vga.hblnk;
      vga_out.vblnk  <= s1_vga.vblnk;
      vga_out.rgb    <= pix;
    end
  end

endmodule

// File: tb/tb_button_panel.sv
// Directed bench for button_panel: pixel vector table plus click/reset sequences.
module tb_button_panel;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       btn_en;
  logic [2:0][4:0][4:0] lbl;
  logic [74:0]      btn_label;
  logic [11:0]      btn_len;
  logic [11:0]      mouse_x, mouse_y;
  logic             mouse_left;
  logic [2:0]       btn_click;

  int checks = 0;
  int errors = 0;

  vga_if vin();
  vga_if vout();

  assign btn_label = lbl;

  button_panel #(.NUM_BTN(3), .MAX_CHARS(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_en     (btn_en),
    .btn_label  (btn_label),
    .btn_len    (btn_len),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .mouse_left (mouse_left),
    .btn_click  (btn_click),
    .vga_in     (vin),
    .vga_out    (vout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] hc, vc;
    logic        hb;
    logic [11:0] up;
    logic [2:0]  en;
    logic [11:0] mx, my;
    logic [11:0] exp;
  } vec_t;

  vec_t vt[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic set_pix(input logic [11:0] hc, input logic [11:0] vc, input logic hb,
                         input logic [11:0] up);
    vin.hcount = hc;
    vin.vcount = vc;
    vin.hblnk  = hb;
    vin.vblnk  = 1'b0;
    vin.rgb    = up;
  endtask

  task automatic watch(input int n, output logic [2:0] seen);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | btn_click;
    end
  endtask

  logic [2:0] seen;

  initial begin
    btn_en     = 3'b111;
    lbl[0]     = {5'd15, 5'd12, 5'd12, 5'd5, 5'd8};   // HELLO
    lbl[1]     = {5'd0, 5'd0, 5'd20, 5'd9, 5'd8};     // HIT
    lbl[2]     = '0;
    btn_len    = {4'd0, 4'd3, 4'd9};                  // button 0 length clamps to 5
    mouse_x    = '0;
    mouse_y    = '0;
    mouse_left = 1'b0;
    vin.hsync  = 1'b1;
    vin.vsync  = 1'b1;
    set_pix(12'd326, 12'd415, 1'b0, 12'h555);

    // button 1 base 00F, text_x = 300 + (100-47)/2 = 326; button 0 text_x = 110
    vt[0]  = '{12'd300, 12'd400, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'h00F};
    vt[1]  = '{12'd326, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hFFF};
    vt[2]  = '{12'd325, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'h00F};
    vt[3]  = '{12'd329, 12'd418, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'h00F};
    vt[4]  = '{12'd340, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hFFF};
    vt[5]  = '{12'd341, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'h00F};
    vt[6]  = '{12'd345, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hFFF};
    vt[7]  = '{12'd250, 12'd420, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hABC};
    vt[8]  = '{12'd300, 12'd400, 1'b1, 12'hABC, 3'b111, 12'd0,   12'd0,   12'h000};
    vt[9]  = '{12'd399, 12'd449, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'h00F};
    vt[10] = '{12'd400, 12'd449, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hABC};
    vt[11] = '{12'd399, 12'd450, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hABC};
    vt[12] = '{12'd110, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hFFF};
    vt[13] = '{12'd109, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hF00};
    vt[14] = '{12'd177, 12'd415, 1'b0, 12'hABC, 3'b111, 12'd0,   12'd0,   12'hFFF};
    vt[15] = '{12'd550, 12'd405, 1'b0, 12'hABC, 3'b111, 12'd550, 12'd420, 12'h4F4};
    vt[16] = '{12'd350, 12'd425, 1'b0, 12'h123, 3'b101, 12'd0,   12'd0,   12'h123};
    vt[17] = '{12'd150, 12'd405, 1'b0, 12'h123, 3'b101, 12'd0,   12'd0,   12'hF00};

    // power-on reset
    #3 rst = 1'b0;
    #2;
    chk("reset_rgb", 32'(vout.rgb), 32'h0);
    chk("reset_hsync", 32'(vout.hsync), 32'h0);
    chk("reset_click", 32'(btn_click), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // pixel vector table
    for (int i = 0; i < 18; i++) begin
      set_pix(vt[i].hc, vt[i].vc, vt[i].hb, vt[i].up);
      vin.hsync = i[0];
      btn_en    = vt[i].en;
      mouse_x   = vt[i].mx;
      mouse_y   = vt[i].my;
      tick();
      tick();
      chk($sformatf("vec%0d_rgb", i), 32'(vout.rgb), 32'(vt[i].exp));
      chk($sformatf("vec%0d_hsync", i), 32'(vout.hsync), 32'(i[0]));
      chk($sformatf("vec%0d_hcount", i), 32'(vout.hcount), 32'(vt[i].hc));
    end

    // reset mid-frame clears outputs without a clock edge
    btn_en    = 3'b111;
    mouse_x   = '0;
    mouse_y   = '0;
    vin.hsync = 1'b1;
    set_pix(12'd326, 12'd415, 1'b0, 12'h555);
    tick();
    tick();
    chk("pre_reset_rgb", 32'(vout.rgb), 32'hFFF);
    rst = 1'b0;
    #1;
    chk("midreset_rgb", 32'(vout.rgb), 32'h0);
    chk("midreset_hsync", 32'(vout.hsync), 32'h0);
    chk("midreset_hcount", 32'(vout.hcount), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // click on button 1
    mouse_x    = 12'd320;
    mouse_y    = 12'd420;
    mouse_left = 1'b1;
    repeat (5) tick();
    set_pix(12'd305, 12'd405, 1'b0, 12'h555);
    tick();
    tick();
    chk("pressed_bg", 32'(vout.rgb), 32'h007);
    repeat (3) tick();
    mouse_left = 1'b0;
    repeat (3) tick();
    chk("click_early", 32'(btn_click), 32'h0);
    tick();
    chk("click_pulse", 32'(btn_click), 32'h2);
    tick();
    chk("click_one_cycle", 32'(btn_click), 32'h0);
    tick();
    chk("hover_after_click", 32'(vout.rgb), 32'h44F);

    // drag-off: press button 0, release elsewhere
    mouse_x    = 12'd150;
    mouse_y    = 12'd420;
    mouse_left = 1'b1;
    repeat (6) tick();
    mouse_x = 12'd700;
    mouse_y = 12'd300;
    repeat (2) tick();
    mouse_left = 1'b0;
    watch(8, seen);
    chk("dragoff_no_click", 32'(seen), 32'h0);
    set_pix(12'd150, 12'd405, 1'b0, 12'h555);
    tick();
    tick();
    chk("dragoff_idle_bg", 32'(vout.rgb), 32'hF00);

    // click on a disabled button is ignored
    btn_en     = 3'b101;
    mouse_x    = 12'd350;
    mouse_y    = 12'd425;
    mouse_left = 1'b1;
    repeat (6) tick();
    mouse_left = 1'b0;
    watch(8, seen);
    chk("disabled_no_click", 32'(seen), 32'h0);

    // enable dropped while pressed aborts the press
    btn_en     = 3'b111;
    mouse_left = 1'b1;
    repeat (6) tick();
    btn_en = 3'b101;
    tick();
    btn_en     = 3'b111;
    mouse_left = 1'b0;
    watch(8, seen);
    chk("en_drop_no_click", 32'(seen), 32'h0);

    // reset during a press aborts it
    mouse_left = 1'b1;
    repeat (6) tick();
    rst        = 1'b0;
    mouse_left = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    watch(8, seen);
    chk("reset_press_no_click", 32'(seen), 32'h0);

    // normal click still works afterwards
    mouse_left = 1'b1;
    repeat (6) tick();
    mouse_left = 1'b0;
    watch(8, seen);
    chk("click_after_reset", 32'(seen), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
